cpc_io_fabric: RTL and testbench

Parametrised Z80 I/O-cycle fabric for the CPC core. It replaces the fixed per-peripheral `oe_n` priority case and the ad-hoc write-edge detector with one block. The block decodes each I/O cycle against NCH programmable address windows and inserts per-channel wait states. It issues one-cycle read/write strobes and holds the registered read data for the CPU. It sits between the CPU bus (sampled in the `ck16` domain) and the peripherals (CRTC, PPI, FDC, and future expansions).

---
 rtl/cpc_io_pkg.sv | 14 +
 rtl/cpc_io_prio.sv | 33 +++
 rtl/cpc_io_fabric.sv | 182 ++++++++++++++++++
 tb/tb_cpc_io_fabric.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpc_io_pkg.sv
// Shared definitions for the CPC I/O-cycle fabric: FSM state encoding and
// the value the CPU reads back when no peripheral answers.
package cpc_io_pkg;

    typedef enum logic [1:0] {
        IO_IDLE,
        IO_WAIT,
        IO_ACTIVE,
        IO_HOLD
    } io_state_e;

    localparam logic [7:0] IO_DEFAULT_DATA = 8'hFF;

endpackage

// File: rtl/cpc_io_prio.sv
// Combinational address-window match for all channels, lowest-index
// priority select, and detection of more than one matching window.
module cpc_io_prio #(
    parameter int NCH = 4,
    parameter int AW  = 16,
    parameter int IW  = 2
) (
    input  logic [AW-1:0]     addr,
    input  logic [NCH*AW-1:0] mask,
    input  logic [NCH*AW-1:0] value,
    output logic              hit,
    output logic [IW-1:0]     idx,
    output logic              multi
);

    logic [4:0] nhits;

    // Scanning from the top down lets the lowest matching index overwrite idx last.
    always_comb begin
        hit   = 1'b0;
        idx   = '0;
        nhits = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if ((addr & mask[i*AW +: AW]) == (value[i*AW +: AW] & mask[i*AW +: AW])) begin
                hit   = 1'b1;
                idx   = IW'(i);
                nhits = nhits + 5'd1;
            end
        end
        multi = (nhits >= 5'd2);
    end

endmodule

// File: rtl/cpc_io_fabric.sv
// Z80 I/O-cycle fabric: samples the CPU bus, decodes against programmable
// windows, inserts per-channel wait states and issues one-cycle strobes.
module cpc_io_fabric
    import cpc_io_pkg::*;
#(
    parameter int NCH = 4,
    parameter int AW  = 16,
    parameter int DW  = 8,
    parameter int WW  = 4
) (
    input  logic              ck16,
    input  logic              rst,
    input  logic [AW-1:0]     cpu_addr,
    input  logic              iorq_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              m1_n,
    input  logic [DW-1:0]     cpu_dout,
    output logic [DW-1:0]     cpu_din,
    output logic              wait_n,
    input  logic [NCH*AW-1:0] ch_mask,
    input  logic [NCH*AW-1:0] ch_value,
    input  logic [NCH*WW-1:0] ch_waits,
    input  logic [NCH*DW-1:0] ch_rdata,
    output logic [NCH-1:0]    ch_rd_stb,
    output logic [NCH-1:0]    ch_wr_stb,
    output logic [DW-1:0]     ch_wdata,
    output logic [AW-1:0]     ch_addr,
    output logic              conflict
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    io_state_e       state_q;
    logic            act;
    logic            act_q;
    logic            rd_q;
    logic [AW-1:0]   smp_addr_q;
    logic [DW-1:0]   smp_dout_q;
    logic            dir_rd_q;
    logic [IW-1:0]   idx_q;
    logic [WW-1:0]   cnt_q;
    logic [DW-1:0]   cpu_din_q;
    logic [DW-1:0]   wdata_q;
    logic [AW-1:0]   addr_q;
    logic            wait_n_q;
    logic            conflict_q;
    logic [NCH-1:0]  rd_stb_q;
    logic [NCH-1:0]  wr_stb_q;

    logic            p_hit;
    logic [IW-1:0]   p_idx;
    logic            p_multi;
    logic [IW-1:0]   win_d;
    logic [NCH-1:0]  onehot_d;
    logic [WW-1:0]   waits_arr [NCH];
    logic [DW-1:0]   rdata_arr [NCH];

    assign act = !iorq_n && m1_n && (!rd_n || !wr_n);

    for (genvar g = 0; g < NCH; g++) begin : g_unpack
        assign waits_arr[g] = ch_waits[g*WW +: WW];
        assign rdata_arr[g] = ch_rdata[g*DW +: DW];
    end

    // Decode works on the sampled address so the whole cycle sees one stable value.
    cpc_io_prio #(
        .NCH (NCH),
        .AW  (AW),
        .IW  (IW)
    ) u_prio (
        .addr  (smp_addr_q),
        .mask  (ch_mask),
        .value (ch_value),
        .hit   (p_hit),
        .idx   (p_idx),
        .multi (p_multi)
    );

    assign win_d    = (state_q == IO_IDLE) ? p_idx : idx_q;
    assign onehot_d = NCH'(1) << win_d;

    always_ff @(posedge ck16 or posedge rst) begin
        if (rst) begin
            state_q    <= IO_IDLE;
            act_q      <= 1'b0;
            rd_q       <= 1'b0;
            smp_addr_q <= '0;
            smp_dout_q <= '0;
            dir_rd_q   <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
            cpu_din_q  <= DW'(IO_DEFAULT_DATA);
            wdata_q    <= '0;
            addr_q     <= '0;
            wait_n_q   <= 1'b1;
            conflict_q <= 1'b0;
            rd_stb_q   <= '0;
            wr_stb_q   <= '0;
        end else begin
            act_q      <= act;
            rd_q       <= !rd_n;
            smp_addr_q <= cpu_addr;
            smp_dout_q <= cpu_dout;
            rd_stb_q   <= '0;
            wr_stb_q   <= '0;

            case (state_q)
                IO_IDLE: begin
                    if (act_q) begin
                        addr_q   <= smp_addr_q;
                        wdata_q  <= smp_dout_q;
                        dir_rd_q <= rd_q;
                        idx_q    <= p_idx;
                        if (p_multi) begin
                            conflict_q <= 1'b1;
                        end
                        if (!p_hit) begin
                            state_q <= IO_HOLD;
                            if (rd_q) begin
                                cpu_din_q <= DW'(IO_DEFAULT_DATA);
                            end
                        end else if (waits_arr[p_idx] == '0) begin
                            state_q <= IO_ACTIVE;
                            if (rd_q) begin
                                rd_stb_q <= onehot_d;
                            end else begin
                                wr_stb_q <= onehot_d;
                            end
                        end else begin
                            state_q  <= IO_WAIT;
                            cnt_q    <= waits_arr[p_idx];
                            wait_n_q <= 1'b0;
                        end
                    end
                end

                // An aborted cycle leaves without a strobe, even on the last wait count.
                IO_WAIT: begin
                    if (!act_q) begin
                        state_q  <= IO_IDLE;
                        wait_n_q <= 1'b1;
                    end else if (cnt_q == WW'(1)) begin
                        state_q  <= IO_ACTIVE;
                        wait_n_q <= 1'b1;
                        if (dir_rd_q) begin
                            rd_stb_q <= onehot_d;
                        end else begin
                            wr_stb_q <= onehot_d;
                        end
                    end else begin
                        cnt_q <= cnt_q - WW'(1);
                    end
                end

                IO_ACTIVE: begin
                    if (dir_rd_q) begin
                        cpu_din_q <= rdata_arr[idx_q];
                    end
                    state_q <= IO_HOLD;
                end

                IO_HOLD: begin
                    if (!act_q) begin
                        state_q <= IO_IDLE;
                    end
                end

                default: state_q <= IO_IDLE;
            endcase
        end
    end

    assign cpu_din   = cpu_din_q;
    assign wait_n    = wait_n_q;
    assign ch_rd_stb = rd_stb_q;
    assign ch_wr_stb = wr_stb_q;
    assign ch_wdata  = wdata_q;
    assign ch_addr   = addr_q;
    assign conflict  = conflict_q;

endmodule

// File: tb/tb_cpc_io_fabric.sv
// Directed bench for cpc_io_fabric: a schedule-based timing model checked every
// cycle, plus literal expectations at the end of each scenario.
module tb_cpc_io_fabric;

    localparam int NCH = 4;
    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int WW  = 4;

    logic              ck16 = 1'b0;
    logic              rst;
    logic [AW-1:0]     cpuAddr;
    logic              iorqN, rdN, wrN, m1N;
    logic [DW-1:0]     cpuDout;
    logic [DW-1:0]     cpuDin;
    logic              waitN;
    logic [NCH*AW-1:0] maskBus, valueBus;
    logic [NCH*WW-1:0] waitsBus;
    logic [NCH*DW-1:0] rdataBus;
    logic [NCH-1:0]    chRdStb, chWrStb;
    logic [DW-1:0]     chWdata;
    logic [AW-1:0]     chAddr;
    logic              conflict;

    logic [AW-1:0] cfgMask  [NCH];
    logic [AW-1:0] cfgValue [NCH];
    logic [WW-1:0] cfgWaits [NCH];
    logic [DW-1:0] cfgRdata [NCH];

    int total = 0;
    int bad   = 0;

    int        cyc = 0;
    bit        txnValid = 1'b0;
    int        e0 = 0;
    int        txHold, txW, txWin;
    bit        txHit, txRd, txMulti;
    logic [7:0]  txRdata, txDout;
    logic [15:0] txAddr;
    logic [7:0]  mDin = 8'hFF;
    bit          mConflict = 1'b0;

    always #5 ck16 = ~ck16;

    always @(posedge ck16) cyc++;

    always_comb begin
        maskBus  = '0;
        valueBus = '0;
        waitsBus = '0;
        rdataBus = '0;
        for (int i = 0; i < NCH; i++) begin
            maskBus[i*AW +: AW]  = cfgMask[i];
            valueBus[i*AW +: AW] = cfgValue[i];
            waitsBus[i*WW +: WW] = cfgWaits[i];
            rdataBus[i*DW +: DW] = cfgRdata[i];
        end
    end

    cpc_io_fabric #(.NCH(NCH), .AW(AW), .DW(DW), .WW(WW)) dut (
        .ck16      (ck16),
        .rst       (rst),
        .cpu_addr  (cpuAddr),
        .iorq_n    (iorqN),
        .rd_n      (rdN),
        .wr_n      (wrN),
        .m1_n      (m1N),
        .cpu_dout  (cpuDout),
        .cpu_din   (cpuDin),
        .wait_n    (waitN),
        .ch_mask   (maskBus),
        .ch_value  (valueBus),
        .ch_waits  (waitsBus),
        .ch_rdata  (rdataBus),
        .ch_rd_stb (chRdStb),
        .ch_wr_stb (chWrStb),
        .ch_wdata  (chWdata),
        .ch_addr   (chAddr),
        .conflict  (conflict)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drive a cycle and record, from the window rules, what it must produce.
    task automatic startTxn(input logic [15:0] addr, input bit isRd, input logic [7:0] dout,
                            input int hold, input bit inta);
        int hits;
        cpuAddr = addr;
        cpuDout = dout;
        iorqN   = 1'b0;
        m1N     = inta ? 1'b0 : 1'b1;
        rdN     = isRd ? 1'b0 : 1'b1;
        wrN     = isRd ? 1'b1 : 1'b0;
        e0      = cyc + 1;
        txHold  = hold;
        txRd    = isRd;
        txAddr  = addr;
        txDout  = dout;
        txHit   = 1'b0;
        txWin   = 0;
        hits    = 0;
        for (int i = 0; i < NCH; i++) begin
            if ((addr & cfgMask[i]) == (cfgValue[i] & cfgMask[i])) begin
                if (!txHit) txWin = i;
                txHit = 1'b1;
                hits++;
            end
        end
        txMulti  = (hits >= 2);
        txW      = int'(cfgWaits[txWin]);
        txRdata  = cfgRdata[txWin];
        txnValid = !inta;
    endtask

    task automatic endTxn();
        iorqN = 1'b1;
        rdN   = 1'b1;
        wrN   = 1'b1;
        m1N   = 1'b1;
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input bit isRd, input logic [7:0] dout,
                                 input int hold, input bit inta);
        startTxn(addr, isRd, dout, hold, inta);
        repeat (hold) @(posedge ck16);
        #1;
        endTxn();
        repeat (6) @(posedge ck16);
        #1;
    endtask

    // k counts edges since the edge that first sampled the active cycle.
    always @(negedge ck16) begin
        logic       expWait;
        logic [3:0] expRd, expWr;
        int         k;
        int         lowEnd;
        bit         strobes;
        expWait = 1'b1;
        expRd   = '0;
        expWr   = '0;
        k       = cyc - e0;
        if (txnValid) begin
            if (txHit) begin
                lowEnd  = (txW < txHold) ? txW : txHold;
                strobes = (txHold >= txW + 1);
                if (k >= 1 && k <= lowEnd) expWait = 1'b0;
                if (strobes && k == txW + 1) begin
                    if (txRd) expRd[txWin] = 1'b1;
                    else      expWr[txWin] = 1'b1;
                    checkOutput("ch_addr at strobe", 32'(chAddr), 32'(txAddr));
                    if (!txRd) checkOutput("ch_wdata at strobe", 32'(chWdata), 32'(txDout));
                end
                if (strobes && txRd && k == txW + 2) mDin = txRdata;
            end else if (txRd && k == 1) begin
                mDin = 8'hFF;
            end
            if (txMulti && k == 1) mConflict = 1'b1;
        end
        checkOutput("wait_n", 32'(waitN), 32'(expWait));
        checkOutput("ch_rd_stb", 32'(chRdStb), 32'(expRd));
        checkOutput("ch_wr_stb", 32'(chWrStb), 32'(expWr));
        checkOutput("cpu_din", 32'(cpuDin), 32'(mDin));
        checkOutput("conflict", 32'(conflict), 32'(mConflict));
    end

    initial begin
        int lowCnt, stbCnt;
        rst     = 1'b1;
        cpuAddr = '0;
        cpuDout = '0;
        endTxn();
        cfgMask[0] = 16'h4000; cfgValue[0] = 16'h0000; cfgWaits[0] = 4'd0; cfgRdata[0] = 8'h5A;
        cfgMask[1] = 16'hFF00; cfgValue[1] = 16'hF700; cfgWaits[1] = 4'd1; cfgRdata[1] = 8'h3C;
        cfgMask[2] = 16'hFFFF; cfgValue[2] = 16'hFB7F; cfgWaits[2] = 4'd3; cfgRdata[2] = 8'h77;
        cfgMask[3] = 16'hFF00; cfgValue[3] = 16'hFA00; cfgWaits[3] = 4'd2; cfgRdata[3] = 8'h99;

        repeat (3) @(posedge ck16);
        #1;
        checkOutput("reset cpu_din", 32'(cpuDin), 32'hFF);
        checkOutput("reset wait_n", 32'(waitN), 32'h1);
        checkOutput("reset strobes", 32'({chRdStb, chWrStb}), 32'h0);
        checkOutput("reset ch_addr", 32'(chAddr), 32'h0);
        checkOutput("reset ch_wdata", 32'(chWdata), 32'h0);
        checkOutput("reset conflict", 32'(conflict), 32'h0);
        rst = 1'b0;
        repeat (2) @(posedge ck16);
        #1;

        // Channel 0 read, no wait states.
        startTxn(16'hBC00, 1'b1, 8'h00, 6, 1'b0);
        @(posedge ck16); #1;
        checkOutput("rd0 edge0 strobe", 32'(chRdStb), 32'h0);
        @(posedge ck16); #1;
        checkOutput("rd0 cycle1 strobe", 32'(chRdStb), 32'h1);
        checkOutput("rd0 wait_n", 32'(waitN), 32'h1);
        @(posedge ck16); #1;
        checkOutput("rd0 data edge2", 32'(cpuDin), 32'h5A);
        repeat (3) @(posedge ck16);
        #1;
        endTxn();
        repeat (6) @(posedge ck16);
        #1;

        // Channel 2 write with three wait states, act held for 20 samples.
        lowCnt = 0;
        stbCnt = 0;
        startTxn(16'hFB7F, 1'b0, 8'hC3, 20, 1'b0);
        repeat (20) begin
            @(posedge ck16); #1;
            if (!waitN) lowCnt++;
            if (chWrStb != 4'b0000) stbCnt++;
        end
        endTxn();
        repeat (6) @(posedge ck16);
        #1;
        checkOutput("wr2 wait cycles", 32'(lowCnt), 32'd3);
        checkOutput("wr2 strobe count", 32'(stbCnt), 32'd1);
        checkOutput("wr2 ch_wdata", 32'(chWdata), 32'hC3);
        checkOutput("wr2 ch_addr", 32'(chAddr), 32'hFB7F);

        applyStimulus(16'hFFFF, 1'b1, 8'h00, 5, 1'b0);
        checkOutput("nohit cpu_din", 32'(cpuDin), 32'hFF);
        checkOutput("nohit conflict", 32'(conflict), 32'h0);

        // Channel 3 moved on top of channel 1.
        cfgValue[3] = 16'hF700;
        applyStimulus(16'hF710, 1'b1, 8'h00, 8, 1'b0);
        checkOutput("overlap conflict", 32'(conflict), 32'h1);
        checkOutput("overlap cpu_din", 32'(cpuDin), 32'h3C);

        applyStimulus(16'hF710, 1'b1, 8'h00, 6, 1'b1);
        checkOutput("inta cpu_din", 32'(cpuDin), 32'h3C);
        checkOutput("inta conflict kept", 32'(conflict), 32'h1);

        applyStimulus(16'hFB7F, 1'b0, 8'h11, 2, 1'b0);
        checkOutput("abort wait_n", 32'(waitN), 32'h1);
        checkOutput("abort conflict kept", 32'(conflict), 32'h1);

        // Reset while channel 2 (five waits) has its count at 2.
        cfgWaits[2] = 4'd5;
        startTxn(16'hFB7F, 1'b0, 8'h22, 100, 1'b0);
        repeat (5) @(posedge ck16);
        #1;
        checkOutput("midwait wait_n", 32'(waitN), 32'h0);
        rst = 1'b1;
        endTxn();
        txnValid  = 1'b0;
        mDin      = 8'hFF;
        mConflict = 1'b0;
        repeat (3) @(posedge ck16);
        #1;
        checkOutput("rst cpu_din", 32'(cpuDin), 32'hFF);
        checkOutput("rst wait_n", 32'(waitN), 32'h1);
        checkOutput("rst conflict", 32'(conflict), 32'h0);
        checkOutput("rst ch_addr", 32'(chAddr), 32'h0);
        checkOutput("rst ch_wdata", 32'(chWdata), 32'h0);
        rst = 1'b0;
        repeat (3) @(posedge ck16);
        #1;

        applyStimulus(16'hBC00, 1'b1, 8'h00, 6, 1'b0);
        checkOutput("recover cpu_din", 32'(cpuDin), 32'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
